// File: rtl/pulse_request_arbiter_pkg.sv
// pulse_request_arbiter_pkg: shared FSM state encoding and round-robin selection helper.
//   state_e    : IDLE / OFFER / BUSY encoding used by the arbiter FSM
//   rr_select  : pick the first set request at or after ptr, wrapping modulo n (n <= 16)
package pulse_request_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2
    } state_e;

    // Walks ptr, ptr+1, ... modulo n and returns the first requesting index.
    // Equivalent to rotate-by-ptr, priority-encode, un-rotate; req bits >= n are ignored.
    function automatic logic [3:0] rr_select(
        input logic [15:0] req,
        input logic [3:0]  ptr,
        input int unsigned n
    );
        logic [3:0]  sel;
        logic        hit;
        int unsigned idx;
        sel = '0;
        hit = 1'b0;
        for (int unsigned k = 0; k < 16; k++) begin
            idx = (32'(ptr) + k) % n;
            if (k < n && !hit && req[idx[3:0]]) begin
                sel = idx[3:0];
                hit = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/pulse_request_arbiter_bank.sv
// pulse_request_arbiter_bank: per-channel rising-edge detect, pending latch and sticky overflow.
//   clk_i       : system clock
//   rst_ni      : asynchronous active-low reset
//   l_i         : level request lines, synchronous to clk_i
//   clr_i       : one-hot pending clear from the arbiter's accept
//   ovf_clr_i   : pulse clearing all overflow flags
//   pending_o   : registered pending-request flags
//   overflow_o  : sticky flags, edge seen while channel already pending
module pulse_request_arbiter_bank #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] l_i,
    input  logic [N-1:0] clr_i,
    input  logic         ovf_clr_i,
    output logic [N-1:0] pending_o,
    output logic [N-1:0] overflow_o
);

    logic [N-1:0] l_q, pending_q, pending_d, overflow_q, overflow_d, edge_w;

    // l_q resets low, so a line already high at reset release yields one edge.
    assign edge_w = l_i & ~l_q;

    // An edge in the same cycle as its own accept re-sets pending, so the new request survives.
    assign pending_d  = (pending_q & ~clr_i) | edge_w;
    // Set takes priority over ovf_clr.
    assign overflow_d = (overflow_q & ~{N{ovf_clr_i}}) | (edge_w & pending_q & ~clr_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            l_q        <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
        end else begin
            l_q        <= l_i;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/pulse_request_arbiter.sv
// pulse_request_arbiter: turns N level request lines into pending requests and grants one
// shared resource round-robin with a valid/ready offer and a done-terminated busy phase.
//   clk_i        : system clock
//   rst_ni       : asynchronous active-low reset
//   l_i          : level request lines; each 0->1 transition is one request
//   ovf_clr_i    : pulse clearing all overflow flags
//   gnt_valid_o  : grant offered to gnt_id_o
//   gnt_id_o     : granted channel, stable while gnt_valid_o is high
//   gnt_ready_i  : resource accepts the offered grant
//   done_i       : resource finished the accepted job
//   busy_o       : high from accept through the cycle done_i is seen
//   pending_o    : per-channel pending flags
//   overflow_o   : per-channel sticky overflow flags
module pulse_request_arbiter
    import pulse_request_arbiter_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [N-1:0]   l_i,
    input  logic           ovf_clr_i,
    output logic           gnt_valid_o,
    output logic [IDW-1:0] gnt_id_o,
    input  logic           gnt_ready_i,
    input  logic           done_i,
    output logic           busy_o,
    output logic [N-1:0]   pending_o,
    output logic [N-1:0]   overflow_o
);

    state_e         state_q, state_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d, rr_ptr_q, rr_ptr_d, sel_w, nxt_ptr_w;
    logic [N-1:0]   clr_w;
    logic           accept_w;

    assign accept_w  = (state_q == OFFER) && gnt_ready_i;
    assign clr_w     = accept_w ? (N'(1) << gnt_id_q) : '0;
    assign sel_w     = IDW'(rr_select(16'(pending_o), 4'(rr_ptr_q), N));
    // After serving k, k+1 gets top priority, making k the lowest.
    assign nxt_ptr_w = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + 1'b1;

    pulse_request_arbiter_bank #(.N(N)) u_bank (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .l_i        (l_i),
        .clr_i      (clr_w),
        .ovf_clr_i  (ovf_clr_i),
        .pending_o  (pending_o),
        .overflow_o (overflow_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            gnt_id_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // done_i is only looked at in BUSY, so done together with ready in OFFER is dropped.
    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        rr_ptr_d = accept_w ? nxt_ptr_w : rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (|pending_o) begin
                    state_d  = OFFER;
                    gnt_id_d = sel_w;
                end
            end
            OFFER:   state_d = gnt_ready_i ? BUSY : OFFER;
            BUSY:    state_d = done_i ? IDLE : BUSY;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_valid_o = (state_q == OFFER);
        busy_o      = (state_q == BUSY);
        gnt_id_o    = gnt_id_q;
    end

endmodule

// File: tb/tb_pulse_request_arbiter.sv
// tb_pulse_request_arbiter: directed vectors with hand-computed expectations for N=4.
module tb_pulse_request_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] l;
    logic       ovf_clr, gnt_ready, done;
    logic       gnt_valid, busy;
    logic [1:0] gnt_id;
    logic [3:0] pending, overflow;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pulse_request_arbiter #(.N(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .l_i         (l),
        .ovf_clr_i   (ovf_clr),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id),
        .gnt_ready_i (gnt_ready),
        .done_i      (done),
        .busy_o      (busy),
        .pending_o   (pending),
        .overflow_o  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Waits (bounded) for an offer, checks id and hold stability, accepts,
    // then returns done three cycles after the accept.
    task automatic serve(input int exp_id, input int hold);
        int n = 0;
        while (!gnt_valid && n < 20) begin
            tick();
            n++;
        end
        chk("offer_valid", 32'(gnt_valid), 1);
        chk("offer_id", 32'(gnt_id), exp_id);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 32'(gnt_valid), 1);
            chk("hold_id", 32'(gnt_id), exp_id);
        end
        gnt_ready = 1'b1;
        tick();
        gnt_ready = 1'b0;
        chk("busy_on", 32'(busy), 1);
        chk("valid_off", 32'(gnt_valid), 0);
        chk("pending_clr", 32'(pending[exp_id]), 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("busy_hold", 32'(busy), 1);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("busy_off", 32'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        l = 4'b0010;
        ovf_clr = 1'b0;
        gnt_ready = 1'b0;
        done = 1'b0;
        tick();
        tick();
        chk("rst_pending", 32'(pending), 0);
        chk("rst_valid", 32'(gnt_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_id", 32'(gnt_id), 0);

        // Line held high across reset release counts as one edge.
        rst_n = 1'b1;
        tick();
        chk("t1_pending", 32'(pending), 4'b0010);
        chk("t1_novalid", 32'(gnt_valid), 0);
        tick();
        chk("t1_valid", 32'(gnt_valid), 1);
        chk("t1_id", 32'(gnt_id), 1);
        serve(1, 0);
        chk("t1_held_no_req", 32'(pending), 0);

        // rr_ptr is now 2: all four rise together, order 2,3,0,1; first offer held 5 cycles.
        l = 4'b0000;
        tick();
        l = 4'b1111;
        tick();
        chk("t3_pending", 32'(pending), 4'b1111);
        serve(2, 5);
        serve(3, 0);
        serve(0, 0);
        serve(1, 0);
        chk("t3_pending_end", 32'(pending), 0);

        // Overflow on a second edge while pending, then clear, then edge in accept cycle.
        l = 4'b0000;
        tick();
        l = 4'b1000;
        tick();
        chk("t5_pending", 32'(pending), 4'b1000);
        tick();
        chk("t5_valid", 32'(gnt_valid), 1);
        chk("t5_id", 32'(gnt_id), 3);
        l = 4'b0000;
        tick();
        l = 4'b1000;
        tick();
        chk("t5_ovf_set", 32'(overflow), 4'b1000);
        chk("t5_pend_keep", 32'(pending), 4'b1000);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t5_ovf_clr", 32'(overflow), 0);
        l = 4'b0000;
        tick();
        l = 4'b1000;
        gnt_ready = 1'b1;
        tick();
        gnt_ready = 1'b0;
        chk("t5_acc_pending", 32'(pending), 4'b1000);
        chk("t5_acc_ovf", 32'(overflow), 0);
        chk("t5_acc_busy", 32'(busy), 1);

        // Build an overflow while BUSY, then assert reset mid-cycle.
        l = 4'b0000;
        tick();
        l = 4'b1000;
        tick();
        chk("t6_ovf_pre", 32'(overflow), 4'b1000);
        chk("t6_busy_pre", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(gnt_valid), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_pending", 32'(pending), 0);
        chk("t6_ovf", 32'(overflow), 0);

        // Fresh reset: rr_ptr=0, pulses on 0 and 2 give grants 0 then 2.
        l = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
        l = 4'b0101;
        tick();
        l = 4'b0000;
        chk("t2_pending", 32'(pending), 4'b0101);
        serve(0, 0);
        chk("t2_pending_mid", 32'(pending), 4'b0100);
        serve(2, 0);
        chk("t2_pending_end", 32'(pending), 0);
        tick();
        chk("t2_idle_valid", 32'(gnt_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
